// File: rtl/fifo_wr_if_if.sv
// Write-side bundle of the async FIFO: producer handshake, FIFO write strobe/data,
// write/read pointers and the derived fill status.
interface fifo_wr_if_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PTR_WIDTH  = 9
);
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  w_en;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  full;
  logic [PTR_WIDTH:0]    waddr;
  logic [PTR_WIDTH:0]    rptr_gray;
  logic [PTR_WIDTH:0]    rptr_sync;
  logic [PTR_WIDTH:0]    wcount;
  logic                  almost_full;

  // Environment side: producer, write pointer block and read-domain pointer source.
  modport master (
    output s_valid, s_data, full, waddr, rptr_gray,
    input  s_ready, w_en, wdata, rptr_sync, wcount, almost_full
  );

  modport slave (
    input  s_valid, s_data, full, waddr, rptr_gray,
    output s_ready, w_en, wdata, rptr_sync, wcount, almost_full
  );
endinterface

// File: rtl/fifo_wr_if.sv
// Async FIFO write front end: 2-entry skid buffer (1-cycle accept-to-w_en), s_ready drops
// once two words are parked behind full; plus read-pointer sync and registered fill/almost-full.
module fifo_wr_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int PTR_WIDTH    = 9,
  parameter int AFULL_THRESH = 496
) (
  input logic         wclk,
  input logic         w_rst_n,
  fifo_wr_if_if.slave bus
);
  localparam int CW = PTR_WIDTH + 1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] skid_q;
  logic                  s_ready_q;
  logic                  out_valid;
  logic                  accept;
  logic                  drain;

  assign out_valid = (state_q != EMPTY);
  assign accept    = bus.s_valid & s_ready_q;
  assign drain     = out_valid & ~bus.full;

  // s_ready is loaded with "next state is not TWO" on every transition.
  always_ff @(posedge wclk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state_q   <= EMPTY;
      wdata_q   <= '0;
      skid_q    <= '0;
      s_ready_q <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          s_ready_q <= 1'b1;
          if (accept) begin
            state_q <= ONE;
            wdata_q <= bus.s_data;
          end
        end
        ONE: begin
          s_ready_q <= 1'b1;
          if (accept && drain) begin
            wdata_q <= bus.s_data;
          end else if (accept) begin
            state_q   <= TWO;
            skid_q    <= bus.s_data;
            s_ready_q <= 1'b0;
          end else if (drain) begin
            state_q <= EMPTY;
          end
        end
        TWO: begin
          if (drain) begin
            state_q   <= ONE;
            wdata_q   <= skid_q;
            s_ready_q <= 1'b1;
          end else begin
            s_ready_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= EMPTY;
          s_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.s_ready = s_ready_q;
  assign bus.w_en    = drain;
  assign bus.wdata   = wdata_q;

  logic [CW-1:0] sync1_q;
  logic [CW-1:0] rptr_sync_q;
  logic [CW-1:0] rbin;
  logic [CW-1:0] wcount_d;
  logic [CW-1:0] wcount_q;
  logic          almost_full_d;
  logic          almost_full_q;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rbin = '0;
    for (int i = 0; i < CW; i++) begin
      rbin[i] = ^(rptr_sync_q >> i);
    end
  end

  // A stale read pointer can only make the count larger, never smaller.
  assign wcount_d      = bus.waddr - rbin;
  assign almost_full_d = (wcount_d >= CW'(AFULL_THRESH));

  always_ff @(posedge wclk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      sync1_q       <= '0;
      rptr_sync_q   <= '0;
      wcount_q      <= '0;
      almost_full_q <= 1'b0;
    end else begin
      sync1_q       <= bus.rptr_gray;
      rptr_sync_q   <= sync1_q;
      wcount_q      <= wcount_d;
      almost_full_q <= almost_full_d;
    end
  end

  assign bus.rptr_sync   = rptr_sync_q;
  assign bus.wcount      = wcount_q;
  assign bus.almost_full = almost_full_q;
endmodule

// File: tb/tb_fifo_wr_if.sv
// Bench for fifo_wr_if: queue-based word model for the skid path, binary-pointer model for fill status.
module tb_fifo_wr_if;
  localparam int DW  = 8;
  localparam int PW  = 9;
  localparam int CW  = PW + 1;
  localparam int THR = 496;

  logic wclk    = 1'b0;
  logic w_rst_n = 1'b1;

  fifo_wr_if_if #(.DATA_WIDTH(DW), .PTR_WIDTH(PW)) bus ();

  fifo_wr_if #(.DATA_WIDTH(DW), .PTR_WIDTH(PW), .AFULL_THRESH(THR)) dut (
    .wclk   (wclk),
    .w_rst_n(w_rst_n),
    .bus    (bus)
  );

  always #5 wclk = ~wclk;

  int errs   = 0;
  int checks = 0;

  // Model: words accepted but not yet written, in order; readiness follows occupancy.
  logic [DW-1:0] mq[$];
  bit            rdy_exp;
  bit            wen_exp;
  bit            have_head;
  logic [DW-1:0] head_exp;

  task automatic drive(input bit v, input logic [DW-1:0] d, input bit f);
    @(negedge wclk);
    bus.s_valid = v;
    bus.s_data  = d;
    bus.full    = f;
    #1;
    have_head = (mq.size() > 0);
    head_exp  = have_head ? mq[0] : '0;
    wen_exp   = have_head && !f;
  endtask

  task automatic commit();
    if (wen_exp) void'(mq.pop_front());
    if (bus.s_valid && rdy_exp) mq.push_back(bus.s_data);
    rdy_exp = (mq.size() < 2);
  endtask

  function automatic logic [CW-1:0] to_gray(input logic [CW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic test_reset();
    bus.s_valid = 0; bus.s_data = '0; bus.full = 0; bus.waddr = '0; bus.rptr_gray = '0;
    #1 w_rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge wclk);
      bus.s_valid   = 1'($urandom_range(0, 1));
      bus.s_data    = DW'($urandom);
      bus.full      = 1'($urandom_range(0, 1));
      bus.waddr     = CW'($urandom);
      bus.rptr_gray = CW'($urandom);
      #1;
      checks++; if (bus.s_ready !== 1'b0) begin errs++; $display("FAIL reset s_ready got=%0b exp=0", bus.s_ready); end
      checks++; if (bus.w_en !== 1'b0) begin errs++; $display("FAIL reset w_en got=%0b exp=0", bus.w_en); end
      checks++; if (bus.wdata !== '0) begin errs++; $display("FAIL reset wdata got=%0h exp=0", bus.wdata); end
      checks++; if (bus.rptr_sync !== '0) begin errs++; $display("FAIL reset rptr_sync got=%0h exp=0", bus.rptr_sync); end
      checks++; if (bus.wcount !== '0) begin errs++; $display("FAIL reset wcount got=%0h exp=0", bus.wcount); end
      checks++; if (bus.almost_full !== 1'b0) begin errs++; $display("FAIL reset almost_full got=%0b exp=0", bus.almost_full); end
    end
    @(negedge wclk);
    bus.s_valid = 0; bus.full = 0; bus.waddr = '0; bus.rptr_gray = '0;
    w_rst_n = 1'b1;
    #1;
    checks++; if (bus.s_ready !== 1'b0) begin errs++; $display("FAIL reset_release s_ready got=%0b exp=0", bus.s_ready); end
    @(posedge wclk); #1;
    checks++; if (bus.s_ready !== 1'b1) begin errs++; $display("FAIL reset_release_edge s_ready got=%0b exp=1", bus.s_ready); end
    mq.delete();
    rdy_exp = 1;
  endtask

  task automatic test_stream();
    logic [DW-1:0] words [4];
    int wen_seen = 0;
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;
    for (int i = 0; i < 7; i++) begin
      drive(i < 4, (i < 4) ? words[i] : 8'h00, 1'b0);
      checks++; if (bus.s_ready !== rdy_exp) begin errs++; $display("FAIL stream s_ready cyc=%0d got=%0b exp=%0b", i, bus.s_ready, rdy_exp); end
      checks++; if (bus.w_en !== wen_exp) begin errs++; $display("FAIL stream w_en cyc=%0d got=%0b exp=%0b", i, bus.w_en, wen_exp); end
      if (have_head) begin
        checks++; if (bus.wdata !== head_exp) begin errs++; $display("FAIL stream wdata cyc=%0d got=%0h exp=%0h", i, bus.wdata, head_exp); end
      end
      if (i >= 1 && i <= 4) begin
        checks++; if (bus.wdata !== words[i-1]) begin errs++; $display("FAIL stream latency cyc=%0d got=%0h exp=%0h", i, bus.wdata, words[i-1]); end
      end
      if (bus.w_en === 1'b1) wen_seen++;
      commit();
    end
    checks++; if (wen_seen != 4) begin errs++; $display("FAIL stream wen_count got=%0d exp=4", wen_seen); end
  endtask

  task automatic test_backpressure();
    int nidx = 0;
    int wen_seen = 0;
    for (int i = 0; i < 24; i++) begin
      bit v = (nidx < 10);
      bit f = (i >= 3 && i < 9);
      bit acc;
      drive(v, DW'(8'hA0 + nidx), f);
      checks++; if (bus.s_ready !== rdy_exp) begin errs++; $display("FAIL backpressure s_ready cyc=%0d got=%0b exp=%0b", i, bus.s_ready, rdy_exp); end
      checks++; if (bus.w_en !== wen_exp) begin errs++; $display("FAIL backpressure w_en cyc=%0d got=%0b exp=%0b", i, bus.w_en, wen_exp); end
      if (have_head) begin
        checks++; if (bus.wdata !== head_exp) begin errs++; $display("FAIL backpressure wdata cyc=%0d got=%0h exp=%0h", i, bus.wdata, head_exp); end
      end
      if (bus.w_en === 1'b1) wen_seen++;
      acc = v && rdy_exp;
      commit();
      if (acc) nidx++;
    end
    checks++; if (wen_seen != 10) begin errs++; $display("FAIL backpressure wen_count got=%0d exp=10", wen_seen); end
  endtask

  task automatic test_random();
    int sent = 0;
    int wen_seen = 0;
    logic [DW-1:0] d = DW'($urandom);
    bit v = 0;
    for (int i = 0; i < 400; i++) begin
      bit f = ($urandom_range(0, 3) == 0);
      bit acc;
      if (!v) v = ($urandom_range(0, 3) != 0);
      if (i >= 396) v = 0;
      drive(v, d, f || (i >= 396 ? 1'b0 : 1'b0));
      checks++; if (bus.s_ready !== rdy_exp) begin errs++; $display("FAIL random s_ready cyc=%0d got=%0b exp=%0b", i, bus.s_ready, rdy_exp); end
      checks++; if (bus.w_en !== wen_exp) begin errs++; $display("FAIL random w_en cyc=%0d got=%0b exp=%0b", i, bus.w_en, wen_exp); end
      if (have_head) begin
        checks++; if (bus.wdata !== head_exp) begin errs++; $display("FAIL random wdata cyc=%0d got=%0h exp=%0h", i, bus.wdata, head_exp); end
      end
      if (bus.w_en === 1'b1) wen_seen++;
      acc = v && rdy_exp;
      commit();
      if (acc) begin
        sent++;
        v = 0;
        d = DW'($urandom);
      end
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, 1'b0);
      checks++; if (bus.w_en !== wen_exp) begin errs++; $display("FAIL random_drain w_en cyc=%0d got=%0b exp=%0b", i, bus.w_en, wen_exp); end
      if (have_head) begin
        checks++; if (bus.wdata !== head_exp) begin errs++; $display("FAIL random_drain wdata cyc=%0d got=%0h exp=%0h", i, bus.wdata, head_exp); end
      end
      if (bus.w_en === 1'b1) wen_seen++;
      commit();
    end
    checks++; if (wen_seen != sent) begin errs++; $display("FAIL random conservation written=%0d accepted=%0d", wen_seen, sent); end
  endtask

  task automatic test_fill_status();
    logic [CW-1:0] exp_cnt;
    @(negedge wclk);
    bus.s_valid = 0; bus.full = 0;
    bus.waddr = CW'(496); bus.rptr_gray = '0;
    repeat (3) @(negedge wclk);
    checks++; if (bus.wcount !== CW'(496)) begin errs++; $display("FAIL afull_496 wcount got=%0d exp=496", bus.wcount); end
    checks++; if (bus.almost_full !== 1'b1) begin errs++; $display("FAIL afull_496 almost_full got=%0b exp=1", bus.almost_full); end
    bus.waddr = CW'(495);
    repeat (3) @(negedge wclk);
    checks++; if (bus.wcount !== CW'(495)) begin errs++; $display("FAIL afull_495 wcount got=%0d exp=495", bus.wcount); end
    checks++; if (bus.almost_full !== 1'b0) begin errs++; $display("FAIL afull_495 almost_full got=%0b exp=0", bus.almost_full); end
    // Wrap case; also pins the two-flop synchroniser delay.
    bus.waddr = CW'(5); bus.rptr_gray = CW'(10'h203);
    @(negedge wclk);
    checks++; if (bus.rptr_sync !== '0) begin errs++; $display("FAIL wrap sync_edge1 got=%0h exp=0", bus.rptr_sync); end
    @(negedge wclk);
    checks++; if (bus.rptr_sync !== CW'(10'h203)) begin errs++; $display("FAIL wrap sync_edge2 got=%0h exp=203", bus.rptr_sync); end
    checks++; if (bus.wcount !== CW'(5)) begin errs++; $display("FAIL wrap wcount_edge2 got=%0d exp=5", bus.wcount); end
    @(negedge wclk);
    checks++; if (bus.wcount !== CW'(8)) begin errs++; $display("FAIL wrap wcount got=%0d exp=8", bus.wcount); end
    checks++; if (bus.almost_full !== 1'b0) begin errs++; $display("FAIL wrap almost_full got=%0b exp=0", bus.almost_full); end
    for (int k = 0; k < 16; k++) begin
      logic [CW-1:0] rb;
      logic [CW-1:0] wa;
      rb = CW'($urandom);
      wa = (k % 2 == 0) ? CW'(rb + CW'($urandom_range(480, 511))) : CW'($urandom);
      bus.waddr = wa;
      bus.rptr_gray = to_gray(rb);
      repeat (3) @(negedge wclk);
      exp_cnt = wa - rb;
      checks++; if (bus.rptr_sync !== to_gray(rb)) begin errs++; $display("FAIL ptr_rand sync k=%0d got=%0h exp=%0h", k, bus.rptr_sync, to_gray(rb)); end
      checks++; if (bus.wcount !== exp_cnt) begin errs++; $display("FAIL ptr_rand wcount k=%0d got=%0d exp=%0d", k, bus.wcount, exp_cnt); end
      checks++; if (bus.almost_full !== (exp_cnt >= CW'(THR))) begin errs++; $display("FAIL ptr_rand almost_full k=%0d got=%0b cnt=%0d", k, bus.almost_full, exp_cnt); end
    end
    bus.waddr = CW'(5); bus.rptr_gray = CW'(10'h203);
    repeat (3) @(negedge wclk);
  endtask

  task automatic test_midop_reset();
    drive(1'b1, 8'hC1, 1'b1); commit();
    drive(1'b1, 8'hC2, 1'b1); commit();
    drive(1'b0, 8'h00, 1'b1);
    checks++; if (bus.s_ready !== 1'b0) begin errs++; $display("FAIL midreset two_state s_ready got=%0b exp=0", bus.s_ready); end
    checks++; if (bus.wdata !== 8'hC1) begin errs++; $display("FAIL midreset held wdata got=%0h exp=c1", bus.wdata); end
    commit();
    @(negedge wclk);
    bus.full = 0; bus.waddr = '0; bus.rptr_gray = '0;
    w_rst_n = 1'b0;
    #1;
    checks++; if (bus.w_en !== 1'b0) begin errs++; $display("FAIL midreset w_en got=%0b exp=0", bus.w_en); end
    checks++; if (bus.s_ready !== 1'b0) begin errs++; $display("FAIL midreset s_ready got=%0b exp=0", bus.s_ready); end
    checks++; if (bus.wdata !== '0) begin errs++; $display("FAIL midreset wdata got=%0h exp=0", bus.wdata); end
    checks++; if (bus.rptr_sync !== '0) begin errs++; $display("FAIL midreset rptr_sync got=%0h exp=0", bus.rptr_sync); end
    checks++; if (bus.wcount !== '0) begin errs++; $display("FAIL midreset wcount got=%0d exp=0", bus.wcount); end
    mq.delete();
    rdy_exp = 0;
    @(negedge wclk);
    w_rst_n = 1'b1;
    @(posedge wclk);
    rdy_exp = 1;
    drive(1'b1, 8'h5A, 1'b0);
    checks++; if (bus.w_en !== 1'b0) begin errs++; $display("FAIL midreset stale w_en got=%0b exp=0", bus.w_en); end
    commit();
    drive(1'b0, 8'h00, 1'b0);
    checks++; if (bus.w_en !== 1'b1) begin errs++; $display("FAIL midreset post w_en got=%0b exp=1", bus.w_en); end
    checks++; if (bus.wdata !== 8'h5A) begin errs++; $display("FAIL midreset post wdata got=%0h exp=5a", bus.wdata); end
    commit();
    drive(1'b0, 8'h00, 1'b0);
    checks++; if (bus.w_en !== 1'b0) begin errs++; $display("FAIL midreset trailing w_en got=%0b exp=0", bus.w_en); end
    commit();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_random();
    test_fill_status();
    test_midop_reset();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
